// File: rtl/jtkcpu_regs_pkg.sv
// Shared definitions for the KCPU register file.
//   - register codes used by src_sel/dst_sel and by the TFR/EXG postbyte
//   - CC bit positions, bit order {E,F,H,I,N,Z,V,C}
//   - CC reset default (F and I set)
//   - regs_t bundles every programmer-visible register so the write-back
//     priority chain can be expressed as a sequence of whole-file updates.
package jtkcpu_regs_pkg;

    localparam logic [2:0] REG_A  = 3'd0;
    localparam logic [2:0] REG_B  = 3'd1;
    localparam logic [2:0] REG_X  = 3'd2;
    localparam logic [2:0] REG_Y  = 3'd3;
    localparam logic [2:0] REG_S  = 3'd4;
    localparam logic [2:0] REG_U  = 3'd5;
    localparam logic [2:0] REG_D  = 3'd6;
    localparam logic [2:0] REG_CC = 3'd7;

    localparam int CC_C = 0;
    localparam int CC_V = 1;
    localparam int CC_Z = 2;
    localparam int CC_N = 3;
    localparam int CC_I = 4;
    localparam int CC_H = 5;
    localparam int CC_F = 6;
    localparam int CC_E = 7;

    localparam logic [7:0] CC_RST_DEFAULT = 8'h50;

    typedef struct packed {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] s;
        logic [15:0] u;
        logic [7:0]  cc;
    } regs_t;

    // True for the 16-bit register codes (X, Y, S, U, D).
    function automatic logic is_wide(input logic [2:0] code);
        logic w;
        case (code)
            REG_X, REG_Y, REG_S, REG_U, REG_D: w = 1'b1;
            REG_A, REG_B, REG_CC:              w = 1'b0;
            default:                           w = 1'b0;
        endcase
        return w;
    endfunction

    // Read a register by code; 8-bit registers come back zero-extended.
    function automatic logic [15:0] get_reg(input regs_t r, input logic [2:0] code);
        logic [15:0] v;
        case (code)
            REG_A:   v = {8'h00, r.a};
            REG_B:   v = {8'h00, r.b};
            REG_X:   v = r.x;
            REG_Y:   v = r.y;
            REG_S:   v = r.s;
            REG_U:   v = r.u;
            REG_D:   v = {r.a, r.b};
            REG_CC:  v = {8'h00, r.cc};
            default: v = 16'h0000;
        endcase
        return v;
    endfunction

    // Write a register by code; 8-bit registers take the low byte.
    function automatic regs_t put_reg(input regs_t r, input logic [2:0] code,
                                      input logic [15:0] v);
        regs_t n;
        n = r;
        case (code)
            REG_A:   n.a  = v[7:0];
            REG_B:   n.b  = v[7:0];
            REG_X:   n.x  = v;
            REG_Y:   n.y  = v;
            REG_S:   n.s  = v;
            REG_U:   n.u  = v;
            REG_D:   begin n.a = v[15:8]; n.b = v[7:0]; end
            REG_CC:  n.cc = v[7:0];
            default: n = r;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/jtkcpu_regxfer.sv
// TFR/EXG width-conversion mux.
//   cur      : current register file contents
//   src_code : postbyte source code
//   dst_code : postbyte destination code
//   to_dst   : value the destination receives (source converted)
//   to_src   : value the source receives on EXG (destination converted)
// An 8-bit register read for a transfer is presented as {8'hFF, r8}; the
// write side (put_reg) keeps only the low byte for 8-bit targets, which
// yields all four width combinations from a single read rule.
module jtkcpu_regxfer
    import jtkcpu_regs_pkg::*;
(
    input  regs_t       cur,
    input  logic [2:0]  src_code,
    input  logic [2:0]  dst_code,
    output logic [15:0] to_dst,
    output logic [15:0] to_src
);

    function automatic logic [15:0] xread(input regs_t r, input logic [2:0] code);
        logic [15:0] v;
        v = get_reg(r, code);
        if (is_wide(code)) begin
            return v;
        end else begin
            return {8'hFF, v[7:0]};
        end
    endfunction

    assign to_dst = xread(cur, src_code);
    assign to_src = xread(cur, dst_code);

endmodule

// File: rtl/jtkcpu_regs.sv
// KCPU programmer-visible register file and ALU write-back stage.
//   rst/clk/cen          : async active-high reset, clock, clock enable
//   src_sel              : register driving opnd0 (combinational)
//   dst_sel/we           : rslt write target and enable
//   we_hi/cc_we          : rslt_hi -> X, cc_alu -> CC
//   rslt/rslt_hi/cc_alu  : ALU results
//   alu_busy             : defers write-back; pend reports a deferred write
//   tfr_en/exg_en/pbyte  : register transfer / exchange, postbyte codes
//   ptr_step/ptr_u/ptr_dec/ptr_two : S/U +-1/+-2 step
//   opnd0, cc, d, x, y, u, s, pend : register file view
module jtkcpu_regs
    import jtkcpu_regs_pkg::*;
#(
    parameter logic [7:0] CC_RST = CC_RST_DEFAULT
)(
    input  logic        rst,
    input  logic        clk,
    input  logic        cen,
    input  logic [2:0]  src_sel,
    input  logic [2:0]  dst_sel,
    input  logic        we,
    input  logic        we_hi,
    input  logic        cc_we,
    input  logic [15:0] rslt,
    input  logic [15:0] rslt_hi,
    input  logic [7:0]  cc_alu,
    input  logic        alu_busy,
    input  logic        tfr_en,
    input  logic        exg_en,
    input  logic [7:0]  pbyte,
    input  logic        ptr_step,
    input  logic        ptr_u,
    input  logic        ptr_dec,
    input  logic        ptr_two,
    output logic [15:0] opnd0,
    output logic [7:0]  cc,
    output logic        pend,
    output logic [15:0] d,
    output logic [15:0] x,
    output logic [15:0] y,
    output logic [15:0] u,
    output logic [15:0] s
);

    regs_t       regs_r;
    regs_t       regs_nxt_s;
    logic        pend_r, pend_nxt_s;
    logic [2:0]  pdst_r, pdst_nxt_s;
    logic        pwe_r, pwe_nxt_s;
    logic        phi_r, phi_nxt_s;
    logic        pcc_r, pcc_nxt_s;

    logic        xfer_s;
    logic        we_new_s, cc_new_s;
    logic        wr_we_s, wr_hi_s, wr_cc_s;
    logic [2:0]  wr_dst_s;
    logic [2:0]  xsrc_s, xdst_s;
    logic        tfr_do_s, exg_do_s;
    logic [15:0] to_dst_s, to_src_s;
    logic [15:0] step_s, ptr_old_s, ptr_new_s;
    regs_t       wb_we_s, wb_hi_s, wb_cc_s, xf1_s, xf2_s;
    logic        unused_s;

    // Postbyte bits 7 and 3 carry no meaning for this block.
    assign unused_s = ^{pbyte[7], pbyte[3]};

    assign xsrc_s   = pbyte[6:4];
    assign xdst_s   = pbyte[2:0];
    assign xfer_s   = tfr_en | exg_en;
    // A transfer in the same cycle suppresses the ALU write-back.
    assign we_new_s = we & ~xfer_s;
    assign cc_new_s = cc_we & ~xfer_s;

    // Choose which write-back applies this cycle and manage the pending latch.
    always_comb begin
        wr_we_s    = 1'b0;
        wr_hi_s    = 1'b0;
        wr_cc_s    = 1'b0;
        wr_dst_s   = dst_sel;
        pend_nxt_s = pend_r;
        pdst_nxt_s = pdst_r;
        pwe_nxt_s  = pwe_r;
        phi_nxt_s  = phi_r;
        pcc_nxt_s  = pcc_r;
        if (pend_r) begin
            // Deferred write: latched target, live data once busy drops.
            wr_dst_s = pdst_r;
            if (!alu_busy) begin
                wr_we_s    = pwe_r;
                wr_hi_s    = phi_r;
                wr_cc_s    = pcc_r;
                pend_nxt_s = 1'b0;
            end else begin
                pend_nxt_s = 1'b1;
            end
        end else if (alu_busy) begin
            if (we_new_s | we_hi | cc_new_s) begin
                pend_nxt_s = 1'b1;
                pdst_nxt_s = dst_sel;
                pwe_nxt_s  = we_new_s;
                phi_nxt_s  = we_hi;
                pcc_nxt_s  = cc_new_s;
            end else begin
                pend_nxt_s = 1'b0;
            end
        end else begin
            wr_we_s = we_new_s;
            wr_hi_s = we_hi;
            wr_cc_s = cc_new_s;
        end
    end

    // Update chain, lowest priority first: later stages override earlier ones.
    assign wb_we_s = wr_we_s ? put_reg(regs_r,  wr_dst_s, rslt)   : regs_r;
    assign wb_hi_s = wr_hi_s ? put_reg(wb_we_s, REG_X,    rslt_hi) : wb_we_s;
    assign wb_cc_s = wr_cc_s ? put_reg(wb_hi_s, REG_CC,   {8'h00, cc_alu}) : wb_hi_s;

    jtkcpu_regxfer u_xfer (
        .cur      (regs_r),
        .src_code (xsrc_s),
        .dst_code (xdst_s),
        .to_dst   (to_dst_s),
        .to_src   (to_src_s)
    );

    assign tfr_do_s = tfr_en & (xsrc_s != xdst_s);
    assign exg_do_s = exg_en & ~tfr_en & (xsrc_s != xdst_s);
    assign xf1_s    = (tfr_do_s | exg_do_s) ? put_reg(wb_cc_s, xdst_s, to_dst_s) : wb_cc_s;
    assign xf2_s    = exg_do_s ? put_reg(xf1_s, xsrc_s, to_src_s) : xf1_s;

    // Stack pointer step wraps naturally in 16 bits.
    assign step_s     = ptr_two ? 16'd2 : 16'd1;
    assign ptr_old_s  = ptr_u ? regs_r.u : regs_r.s;
    assign ptr_new_s  = ptr_dec ? (ptr_old_s - step_s) : (ptr_old_s + step_s);
    assign regs_nxt_s = ptr_step ? put_reg(xf2_s, ptr_u ? REG_U : REG_S, ptr_new_s) : xf2_s;

    // Register file and pending-write state; everything advances on cen only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_r <= '{a: 8'h00, b: 8'h00, x: 16'h0000, y: 16'h0000,
                        s: 16'h0000, u: 16'h0000, cc: CC_RST};
            pend_r <= 1'b0;
            pdst_r <= 3'd0;
            pwe_r  <= 1'b0;
            phi_r  <= 1'b0;
            pcc_r  <= 1'b0;
        end else if (cen) begin
            regs_r <= regs_nxt_s;
            pend_r <= pend_nxt_s;
            pdst_r <= pdst_nxt_s;
            pwe_r  <= pwe_nxt_s;
            phi_r  <= phi_nxt_s;
            pcc_r  <= pcc_nxt_s;
        end
    end

    assign opnd0 = get_reg(regs_r, src_sel);
    assign cc    = regs_r.cc;
    assign pend  = pend_r;
    assign d     = {regs_r.a, regs_r.b};
    assign x     = regs_r.x;
    assign y     = regs_r.y;
    assign u     = regs_r.u;
    assign s     = regs_r.s;

endmodule

// File: tb/tb_jtkcpu_regs.sv
// Self-checking bench for jtkcpu_regs: a behavioural model of the register
// file, a per-cycle compare process, and directed vectors with literal
// expectations.
module tb_jtkcpu_regs;

    logic        clk = 1'b0;
    logic        rst, cen;
    logic [2:0]  src_sel, dst_sel;
    logic        we, we_hi, cc_we;
    logic [15:0] rslt, rslt_hi;
    logic [7:0]  cc_alu;
    logic        alu_busy, tfr_en, exg_en;
    logic [7:0]  pbyte;
    logic        ptr_step, ptr_u, ptr_dec, ptr_two;
    logic [15:0] opnd0, d, x, y, u, s;
    logic [7:0]  cc;
    logic        pend;

    int n_checks = 0;
    int n_fail   = 0;

    jtkcpu_regs dut (
        .rst(rst), .clk(clk), .cen(cen), .src_sel(src_sel), .dst_sel(dst_sel),
        .we(we), .we_hi(we_hi), .cc_we(cc_we), .rslt(rslt), .rslt_hi(rslt_hi),
        .cc_alu(cc_alu), .alu_busy(alu_busy), .tfr_en(tfr_en), .exg_en(exg_en),
        .pbyte(pbyte), .ptr_step(ptr_step), .ptr_u(ptr_u), .ptr_dec(ptr_dec),
        .ptr_two(ptr_two), .opnd0(opnd0), .cc(cc), .pend(pend),
        .d(d), .x(x), .y(y), .u(u), .s(s)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [7:0]  m_a, m_b, m_cc;
    logic [15:0] m_x, m_y, m_s, m_u;
    logic        m_pend, m_pwe, m_phi, m_pcc;
    logic [2:0]  m_pdst;

    function automatic logic [15:0] m_get(input logic [2:0] c);
        case (c)
            3'd0: return {8'h00, m_a};
            3'd1: return {8'h00, m_b};
            3'd2: return m_x;
            3'd3: return m_y;
            3'd4: return m_s;
            3'd5: return m_u;
            3'd6: return {m_a, m_b};
            default: return {8'h00, m_cc};
        endcase
    endfunction

    // Transfer read: 8-bit registers become {FF, r8}.
    function automatic logic [15:0] m_xread(input logic [2:0] c);
        logic [15:0] v;
        v = m_get(c);
        if (c inside {3'd0, 3'd1, 3'd7}) v = {8'hFF, v[7:0]};
        return v;
    endfunction

    task automatic m_put(input logic [2:0] c, input logic [15:0] v);
        case (c)
            3'd0: m_a = v[7:0];
            3'd1: m_b = v[7:0];
            3'd2: m_x = v;
            3'd3: m_y = v;
            3'd4: m_s = v;
            3'd5: m_u = v;
            3'd6: begin m_a = v[15:8]; m_b = v[7:0]; end
            default: m_cc = v[7:0];
        endcase
    endtask

    logic [15:0] o_tsrc, o_tdst, o_ptr, m_delta;
    logic        m_xf;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_a = 8'h00; m_b = 8'h00; m_cc = 8'h50;
            m_x = 16'h0000; m_y = 16'h0000; m_s = 16'h0000; m_u = 16'h0000;
            m_pend = 1'b0; m_pwe = 1'b0; m_phi = 1'b0; m_pcc = 1'b0; m_pdst = 3'd0;
        end else if (cen) begin
            o_tsrc = m_xread(pbyte[6:4]);
            o_tdst = m_xread(pbyte[2:0]);
            o_ptr  = ptr_u ? m_u : m_s;
            m_xf   = tfr_en || exg_en;
            if (m_pend) begin
                if (!alu_busy) begin
                    if (m_pwe) m_put(m_pdst, rslt);
                    if (m_phi) m_x = rslt_hi;
                    if (m_pcc) m_cc = cc_alu;
                    m_pend = 1'b0;
                end
            end else if (alu_busy) begin
                if ((we && !m_xf) || we_hi || (cc_we && !m_xf)) begin
                    m_pend = 1'b1; m_pdst = dst_sel;
                    m_pwe = we && !m_xf; m_phi = we_hi; m_pcc = cc_we && !m_xf;
                end
            end else begin
                if (we && !m_xf) m_put(dst_sel, rslt);
                if (we_hi) m_x = rslt_hi;
                if (cc_we && !m_xf) m_cc = cc_alu;
            end
            if (pbyte[6:4] != pbyte[2:0]) begin
                if (tfr_en) begin
                    m_put(pbyte[2:0], o_tsrc);
                end else if (exg_en) begin
                    m_put(pbyte[2:0], o_tsrc);
                    m_put(pbyte[6:4], o_tdst);
                end
            end
            if (ptr_step) begin
                m_delta = ptr_two ? 16'd2 : 16'd1;
                if (ptr_u) m_u = ptr_dec ? o_ptr - m_delta : o_ptr + m_delta;
                else       m_s = ptr_dec ? o_ptr - m_delta : o_ptr + m_delta;
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare DUT against the model once per cycle, away from the clock edge.
    always @(negedge clk) begin
        #2;
        chk("m_d",     d, {m_a, m_b});
        chk("m_x",     x, m_x);
        chk("m_y",     y, m_y);
        chk("m_s",     s, m_s);
        chk("m_u",     u, m_u);
        chk("m_cc",    {8'h00, cc}, {8'h00, m_cc});
        chk("m_pend",  {15'h0, pend}, {15'h0, m_pend});
        chk("m_opnd0", opnd0, m_get(src_sel));
    end

    task automatic idle();
        cen = 1'b1; src_sel = 3'd0; dst_sel = 3'd0; we = 1'b0; we_hi = 1'b0;
        cc_we = 1'b0; rslt = 16'h0000; rslt_hi = 16'h0000; cc_alu = 8'h00;
        alu_busy = 1'b0; tfr_en = 1'b0; exg_en = 1'b0; pbyte = 8'h00;
        ptr_step = 1'b0; ptr_u = 1'b0; ptr_dec = 1'b0; ptr_two = 1'b0;
    endtask

    task automatic wr(input logic [2:0] dst, input logic [15:0] v);
        dst_sel = dst; rslt = v; we = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        repeat (2) @(negedge clk);
        chk("rst_d", d, 16'h0000);
        chk("rst_cc", {8'h00, cc}, 16'h0050);
        chk("rst_pend", {15'h0, pend}, 16'h0000);
        rst = 1'b0;

        // Direct write to D, then read A through opnd0.
        wr(3'd6, 16'h1234);
        src_sel = 3'd0;
        #1;
        chk("dir_opnd0", opnd0, 16'h0012);
        chk("dir_d", d, 16'h1234);

        // Deferred DIVXB-style write: B and X held behind busy.
        @(negedge clk);
        dst_sel = 3'd1; we = 1'b1; we_hi = 1'b1; alu_busy = 1'b1;
        rslt = 16'hDEAD; rslt_hi = 16'hBEEF;
        @(negedge clk);
        we = 1'b0; we_hi = 1'b0;
        #1;
        chk("def_pend1", {15'h0, pend}, 16'h0001);
        chk("def_hold_d", d, 16'h1234);
        for (int i = 0; i < 4; i++) begin
            rslt = 16'h1000 + 16'(i);
            @(negedge clk);
        end
        chk("def_pend5", {15'h0, pend}, 16'h0001);
        chk("def_hold_x", x, 16'h0000);
        alu_busy = 1'b0; rslt = 16'h0007; rslt_hi = 16'h0003;
        @(negedge clk);
        #1;
        chk("def_b", d, 16'h1207);
        chk("def_x", x, 16'h0003);
        chk("def_pend0", {15'h0, pend}, 16'h0000);

        // TFR A -> X with sign-less FF fill.
        @(negedge clk);
        wr(3'd0, 16'h0080);
        tfr_en = 1'b1; pbyte = 8'h02;
        @(negedge clk);
        tfr_en = 1'b0;
        #1;
        chk("tfr_x", x, 16'hFF80);

        // EXG X <-> Y.
        wr(3'd2, 16'h1111);
        wr(3'd3, 16'h2222);
        exg_en = 1'b1; pbyte = 8'h23;
        @(negedge clk);
        exg_en = 1'b0;
        #1;
        chk("exg_x", x, 16'h2222);
        chk("exg_y", y, 16'h1111);

        // More transfers checked against the model: 16->8, 8<->8, equal codes,
        // and TFR winning over a simultaneous we.
        tfr_en = 1'b1; pbyte = 8'h31; @(negedge clk);
        tfr_en = 1'b0; exg_en = 1'b1; pbyte = 8'h01; @(negedge clk);
        pbyte = 8'h22; @(negedge clk);
        exg_en = 1'b0; tfr_en = 1'b1; pbyte = 8'h04;
        we = 1'b1; dst_sel = 3'd0; rslt = 16'h0055; @(negedge clk);
        idle();

        // Pointer wrap; ptr_step beats a we to the same register.
        wr(3'd4, 16'h0001);
        ptr_step = 1'b1; ptr_u = 1'b0; ptr_dec = 1'b1; ptr_two = 1'b1;
        we = 1'b1; dst_sel = 3'd4; rslt = 16'h1234;
        @(negedge clk);
        idle();
        #1;
        chk("ptr_s_wrap", s, 16'hFFFF);
        wr(3'd5, 16'hFFFF);
        ptr_step = 1'b1; ptr_u = 1'b1;
        @(negedge clk);
        idle();
        #1;
        chk("ptr_u_wrap", u, 16'h0000);
        wr(3'd5, 16'hFFFF);
        ptr_step = 1'b1; ptr_u = 1'b1; ptr_two = 1'b1;
        @(negedge clk);
        idle();
        #1;
        chk("ptr_u_two", u, 16'h0001);

        // Collisions: cc_we beats we to CC, we_hi beats we to X.
        we = 1'b1; dst_sel = 3'd7; rslt = 16'h00AA; cc_we = 1'b1; cc_alu = 8'h0F;
        @(negedge clk);
        idle();
        #1;
        chk("col_cc", {8'h00, cc}, 16'h000F);
        we = 1'b1; dst_sel = 3'd2; rslt = 16'h1111; we_hi = 1'b1; rslt_hi = 16'hBEEF;
        @(negedge clk);
        idle();
        #1;
        chk("col_x", x, 16'hBEEF);
        wr(3'd7, 16'h12A5);

        // cen gating of a plain write.
        cen = 1'b0; we = 1'b1; dst_sel = 3'd3; rslt = 16'h5A5A;
        repeat (3) @(negedge clk);
        chk("cen_hold_y", y, 16'h1111);
        cen = 1'b1;
        @(negedge clk);
        idle();
        #1;
        chk("cen_y", y, 16'h5A5A);

        // cen gating of the pending commit.
        alu_busy = 1'b1; we = 1'b1; dst_sel = 3'd0;
        @(negedge clk);
        we = 1'b0; alu_busy = 1'b0; cen = 1'b0; rslt = 16'h0042;
        repeat (2) @(negedge clk);
        chk("cen_pend", {15'h0, pend}, 16'h0001);
        cen = 1'b1;
        @(negedge clk);
        #1;
        chk("cen_commit_pend", {15'h0, pend}, 16'h0000);
        chk("cen_commit_a", {8'h00, d[15:8]}, 16'h0042);

        // opnd0 for every source code.
        idle();
        for (int i = 0; i < 8; i++) begin
            src_sel = 3'(i);
            @(negedge clk);
        end

        // Mixed traffic against the model.
        for (int i = 0; i < 40; i++) begin
            dst_sel = 3'($urandom_range(0, 7)); src_sel = 3'($urandom_range(0, 7));
            we = 1'($urandom_range(0, 1)); we_hi = ($urandom_range(0, 3) == 0);
            cc_we = 1'($urandom_range(0, 1)); rslt = 16'($urandom);
            rslt_hi = 16'($urandom); cc_alu = 8'($urandom);
            alu_busy = ($urandom_range(0, 3) == 0); cen = ($urandom_range(0, 7) != 0);
            ptr_step = ($urandom_range(0, 3) == 0); ptr_u = 1'($urandom_range(0, 1));
            ptr_dec = 1'($urandom_range(0, 1)); ptr_two = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        idle();
        @(negedge clk);

        // Reset in the middle of a deferred write.
        alu_busy = 1'b1; we = 1'b1; dst_sel = 3'd2; rslt = 16'hFFFF;
        @(negedge clk);
        we = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        chk("arst_d", d, 16'h0000);
        chk("arst_x", x, 16'h0000);
        chk("arst_y", y, 16'h0000);
        chk("arst_s", s, 16'h0000);
        chk("arst_u", u, 16'h0000);
        chk("arst_cc", {8'h00, cc}, 16'h0050);
        chk("arst_pend", {15'h0, pend}, 16'h0000);
        @(negedge clk);
        rst = 1'b0; alu_busy = 1'b0;
        @(negedge clk);
        #1;
        chk("arst_drop_x", x, 16'h0000);
        chk("arst_drop_pend", {15'h0, pend}, 16'h0000);

        @(negedge clk);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
